// File: rtl/if2_pkg.sv
// if2_pkg: shared definitions for the IF2 predecode stage.
//   br_type_t   - branch class reported to / compared with the predictor
//   OP_*        - major opcode values (IR[31:26]) recognised by predecode
//   off16_ext   - {imm16,2'b0} sign-extended (conditional branches, jirl)
//   off26_ext   - {imm26,2'b0} sign-extended (b, bl)
//   is_ret_form - jirl rd=0, rj=1 (function return)
package if2_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,   // conditional branches and plain b
        BR_CALL = 2'b10,   // bl
        BR_JIRL = 2'b11
    } br_type_t;

    localparam logic [5:0] OP_JIRL    = 6'h13;
    localparam logic [5:0] OP_B       = 6'h14;
    localparam logic [5:0] OP_BL      = 6'h15;
    localparam logic [5:0] OP_COND_LO = 6'h16;
    localparam logic [5:0] OP_COND_HI = 6'h1B;

    function automatic logic [31:0] off16_ext(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    // imm26 = {IR[9:0], IR[25:10]}
    function automatic logic [31:0] off26_ext(input logic [25:0] imm26);
        return {{4{imm26[25]}}, imm26, 2'b00};
    endfunction

    // rj_rd = IR[9:0]
    function automatic logic is_ret_form(input logic [9:0] rj_rd);
        return (rj_rd[4:0] == 5'd0) && (rj_rd[9:5] == 5'd1);
    endfunction

endpackage

// File: rtl/if2_ras.sv
// if2_ras: circular return-address stack.
//   clk, rst   - clock, synchronous active-high reset (clears pointer/count)
//   push       - write push_data on top; when full the oldest entry is lost
//   push_data  - return address to push
//   pop        - drop top entry; ignored when empty
//   top        - current top entry (meaningless while empty)
//   empty      - no valid entries
module if2_ras #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] top,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [PW-1:0] ptr;     // next free slot; top lives at ptr-1
    logic [PW:0]   cnt;

    assign empty = (cnt == '0);
    assign top   = mem[ptr - PW'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            // Wrapping the pointer overwrites the oldest entry once full.
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (cnt != (PW+1)'(DEPTH))
                cnt <= cnt + (PW+1)'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/if2_predecode_stage.sv
// if2_predecode_stage: IF2 pipeline register with branch predecode.
// Scans the fetch group for the first taken control transfer, computes the
// next-fetch PC, compares it with the predictor's guess and raises a
// one-cycle redirect on disagreement.
//   in_*            - fetch group + predictor info (valid/ready handshake)
//   out_*           - registered group, truncated mask, decided type/target
//   redirect_o/_pc  - one-cycle front-end redirect
//   flush_i         - backend flush, dominates everything but rst
// Optional macro IF2_RAS_EN: adds an if2_ras return-address stack used to
// predict return-form jirl targets.
module if2_predecode_stage #(
    parameter int FETCH_WIDTH = 2,
    parameter int RAS_DEPTH   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [31:0]                           in_pc,
    input  logic [32*FETCH_WIDTH-1:0]             in_ir,
    input  logic [FETCH_WIDTH-1:0]                in_mask,
    input  logic [1:0]                            in_pred_type,
    input  logic [$clog2(FETCH_WIDTH):0]          in_pred_slot,
    input  logic [31:0]                           in_pred_pc,
    input  logic                                  flush_i,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [31:0]                           out_pc,
    output logic [32*FETCH_WIDTH-1:0]             out_ir,
    output logic [FETCH_WIDTH-1:0]                out_mask,
    output logic [1:0]                            out_type,
    output logic [31:0]                           out_target,
    output logic                                  redirect_o,
    output logic [31:0]                           redirect_pc
);
    import if2_pkg::*;

    localparam int SLOT_W = $clog2(FETCH_WIDTH) + 1;

    if (!(FETCH_WIDTH == 1 || FETCH_WIDTH == 2 || FETCH_WIDTH == 4) ||
        RAS_DEPTH < 4 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("if2_predecode_stage: illegal FETCH_WIDTH or RAS_DEPTH");
    end

    // ---------------- per-slot decode ----------------
    logic [FETCH_WIDTH-1:0][1:0]  slot_type;
    logic [FETCH_WIDTH-1:0][31:0] slot_rel;    // slot PC + offset
    logic [FETCH_WIDTH-1:0]       slot_take;
`ifdef IF2_RAS_EN
    logic [FETCH_WIDTH-1:0]       slot_ret;
    logic [FETCH_WIDTH-1:0][31:0] slot_link;   // slot PC + 4
`endif

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        logic [31:0] ir, pc, off;
        logic [5:0]  op;
        logic        is_cond, is_b, is_bl, is_jirl;

        assign ir      = in_ir[32*i +: 32];
        assign op      = ir[31:26];
        assign pc      = in_pc + 32'(4*i);
        assign is_cond = (op >= OP_COND_LO) && (op <= OP_COND_HI);
        assign is_b    = (op == OP_B);
        assign is_bl   = (op == OP_BL);
        assign is_jirl = (op == OP_JIRL);
        assign off     = (is_b || is_bl) ? off26_ext({ir[9:0], ir[25:10]})
                                         : off16_ext(ir[25:10]);

        assign slot_rel[i]  = pc + off;
        assign slot_type[i] = is_jirl ? BR_JIRL :
                              is_bl   ? BR_CALL :
                              (is_b || is_cond) ? BR_COND : BR_NONE;
        // Backward conditionals are statically taken; forward ones only
        // when the predictor pointed at this slot.
        assign slot_take[i] = in_mask[i] && (is_b || is_bl || is_jirl ||
                              (is_cond && (off[31] || in_pred_slot == SLOT_W'(i))));
`ifdef IF2_RAS_EN
        assign slot_ret[i]  = is_jirl && is_ret_form(ir[9:0]);
        assign slot_link[i] = pc + 32'd4;
`endif
    end

    // ---------------- taken-slot select ----------------
    logic              hit;
    logic [SLOT_W-1:0] sel, last;
    logic [1:0]        hit_type;
    logic [31:0]       hit_rel;
`ifdef IF2_RAS_EN
    logic              hit_ret;
    logic [31:0]       hit_link;
`endif
    logic [FETCH_WIDTH-1:0] mask_d;

    always_comb begin
        hit      = 1'b0;
        sel      = '0;
        last     = '0;
        hit_type = BR_NONE;
        hit_rel  = '0;
`ifdef IF2_RAS_EN
        hit_ret  = 1'b0;
        hit_link = '0;
`endif
        // Descending scan so the lowest taken slot wins.
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (slot_take[i]) begin
                hit      = 1'b1;
                sel      = SLOT_W'(i);
                hit_type = slot_type[i];
                hit_rel  = slot_rel[i];
`ifdef IF2_RAS_EN
                hit_ret  = slot_ret[i];
                hit_link = slot_link[i];
`endif
            end
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (in_mask[i])
                last = SLOT_W'(i);
            mask_d[i] = in_mask[i] && (!hit || SLOT_W'(i) <= sel);
        end
    end

    // ---------------- return-address stack ----------------
    logic        capture;
    logic        ras_use;
    logic [31:0] ras_top;

`ifdef IF2_RAS_EN
    logic ras_empty;

    assign ras_use = hit && (hit_type == BR_JIRL) && hit_ret && !ras_empty;

    if2_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (capture && hit && (hit_type == BR_CALL)),
        .push_data (hit_link),
        .pop       (capture && ras_use),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    assign ras_use = 1'b0;
    assign ras_top = in_pred_pc;
`endif

    // ---------------- decision / compare ----------------
    logic [31:0] tgt_d;
    logic [1:0]  type_d;
    logic        mis_d;

    always_comb begin
        type_d = hit ? hit_type : BR_NONE;
        if (!hit)
            tgt_d = (in_mask == '0) ? in_pc : in_pc + ((32'(last) + 32'd1) << 2);
        else if (hit_type == BR_JIRL)
            tgt_d = ras_use ? ras_top : in_pred_pc;
        else
            tgt_d = hit_rel;

        // An empty group never redirects; a jirl resolved by the predictor
        // itself has nothing better to compare against.
        if (!hit)
            mis_d = (in_mask != '0) && (in_pred_type != BR_NONE);
        else if (hit_type == BR_JIRL && !ras_use)
            mis_d = 1'b0;
        else
            mis_d = (hit_type != in_pred_type) || (sel != in_pred_slot) ||
                    (tgt_d != in_pred_pc);
    end

    // ---------------- pipeline register ----------------
    assign in_ready    = rst || !out_valid || out_ready;
    // Wrong-path groups arriving during a redirect are dropped.
    assign capture     = in_valid && in_ready && !redirect_o && !flush_i && !rst;
    assign redirect_pc = out_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            redirect_o <= 1'b0;
            out_pc     <= '0;
            out_ir     <= '0;
            out_mask   <= '0;
            out_type   <= BR_NONE;
            out_target <= '0;
        end else if (flush_i) begin
            out_valid  <= 1'b0;
            redirect_o <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            redirect_o <= mis_d;
            out_pc     <= in_pc;
            out_ir     <= in_ir;
            out_mask   <= mask_d;
            out_type   <= type_d;
            out_target <= tgt_d;
        end else begin
            redirect_o <= 1'b0;
            if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
